braun_product_accumulator: RTL and testbench
============================================

Name: braun_product_accumulator

Overview:
Downstream consumer of the 4x4 Braun array multiplier. Takes the 8-bit unsigned product P as a stream of valid/ready beats and registers each beat. Sums the beats of a sequence terminated by `in_last` and presents the total as one result beat. This forms the accumulate half of the team's small dot-product / MAC datapath.

Parameters:
ACC_W, 16, accumulator and result width in bits; legal range 8..32.
CNT_W, 4, width of the beat counter reported with each result.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  product beat valid
in_ready  output  1  block can accept a product beat
in_prod  input  8  unsigned product from the multiplier (P)
in_last  input  1  marks final beat of a sequence
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  accumulated sum of the sequence
out_cnt  output  CNT_W  number of beats in the sequence, modulo 2^CNT_W
out_ovf  output  1  sticky: accumulation exceeded 2^ACC_W-1 during the sequence

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - in_ready=1, out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
  - Internal accumulator=0, counter=0, stage-1 valid=0, state=ACCUM.
- Input handshake:
  - A beat is accepted on a rising edge with in_valid && in_ready.
  - in_prod and in_last are sampled only on acceptance.
  - in_ready is combinational: high only in state ACCUM with no stage-1 last pending.
- Pipeline:
  - Stage 1 registers {prod, last, valid} of the accepted beat.
  - Stage 2 adds the stage-1 product, zero-extended to ACC_W+1 bits, to the accumulator.
  - Stage 2 increments the counter.
  - Throughput: one beat per cycle while in_ready is high.
- States:
  - ACCUM: accepting beats.
  - DRAIN: the last beat is in stage 1. in_ready=0.
  - HOLD: result presented. in_ready=0.
- Transitions:
  - ACCUM->DRAIN when a beat with in_last=1 is accepted.
  - DRAIN->HOLD on the next edge. On that edge:
    - Load out_sum with accumulator plus the final product.
    - Load out_cnt with counter+1.
    - Load out_ovf.
    - Set out_valid=1.
    - Clear accumulator, counter and overflow tracking.
  - HOLD->ACCUM on an edge with out_ready=1. That edge clears out_valid; in_ready rises in the following cycle.
- Latency: last beat accepted at edge t -> out_valid high after edge t+2.
- Output stability: out_sum, out_cnt and out_ovf are held stable while out_valid && !out_ready. A result is never dropped or duplicated.
- Arithmetic:
  - Unsigned addition.
  - Default build wraps modulo 2^ACC_W.
  - out_ovf is set if any addition of the sequence carried out of bit ACC_W-1.
- Boundary conditions:
  - Single-beat sequence (in_last on the first beat): out_sum=in_prod, out_cnt=1.
  - Product 0 beats still count.
  - Counter wraps at 2^CNT_W: 16 beats with CNT_W=4 gives out_cnt=0.
  - out_ready held high before out_valid rises: handshake completes on the first edge where out_valid=1.
  - in_valid may be dropped between beats; idle cycles do not affect the sum.
- Reset mid-operation: the asynchronous assertion immediately returns every register to its reset value. The partial sequence and any pending result are discarded.

Optional Feature:
Macro: BRAUN_ACC_SATURATE_EN.
- Defined: any addition exceeding 2^ACC_W-1 clamps the accumulator to 2^ACC_W-1. Later additions in the same sequence stay clamped. out_ovf is still set.
- Undefined: wrap-around as described under Behaviour. out_ovf is still reported.

Test Plan:
- Reset then idle: check reset values. in_ready=1 one cycle after rst_n rises, out_valid stays 0 with no input.
- Four back-to-back beats of 225 (15*15), last on beat 4, out_ready=1 -> out_sum=900, out_cnt=4, out_ovf=0. out_valid rises 2 edges after the 4th acceptance; in_ready=0 during DRAIN/HOLD.
- Single beat in_prod=42 with in_last=1 -> out_sum=42, out_cnt=1. Then hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; out_ready=1 -> handshake completes and in_ready returns next cycle.
- ACC_W=10, five beats of 225:
  - Default build -> out_sum=1125-1024=101, out_ovf=1.
  - With BRAUN_ACC_SATURATE_EN -> out_sum=1023, out_ovf=1.
  - Next sequence of 1 beat of 7 -> out_sum=7, out_ovf=0.
- Gapped input: beats 10, 0, 20 with 3 idle cycles between each -> out_sum=30, out_cnt=3. 16 beats of 1 with CNT_W=4 -> out_sum=16, out_cnt=0.
- Assert rst_n=0 asynchronously mid-sequence after beats 100 and 50:
  - Outputs clear immediately.
  - Then beats 5 and 6 (last) -> out_sum=11, out_cnt=2.

Source files
------------

// File: rtl/braun_product_accumulator.sv
// Accumulates a valid/ready stream of 8-bit Braun multiplier products into one result per sequence.
// Optional macro BRAUN_ACC_SATURATE_EN clamps the accumulator instead of wrapping on overflow.
module braun_product_accumulator #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

    state_e state_q, state_d;

    logic [7:0]       s1_prod_q, s1_prod_d;
    logic             s1_last_q, s1_last_d;
    logic             s1_valid_q, s1_valid_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [ACC_W:0]   sum_ext;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN is entered once the last beat has reached the accumulator
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum: if (s1_valid_q && s1_last_q) state_d = StDrain;
            StDrain: state_d = StHold;
            StHold:  if (out_ready) state_d = StAccum;
            default: state_d = StAccum;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state_q == StAccum) && !(s1_valid_q && s1_last_q);
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

    // Datapath next-state
    always_comb begin
        s1_valid_d  = accept;
        s1_prod_d   = accept ? in_prod : s1_prod_q;
        s1_last_d   = accept ? in_last : 1'b0;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        sum_ext     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, s1_prod_q};

        if (s1_valid_q) begin
`ifdef BRAUN_ACC_SATURATE_EN
            acc_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
            cnt_d = cnt_q + 1'b1;
            ovf_d = ovf_q | sum_ext[ACC_W];
        end

        if (state_q == StDrain) begin
            out_sum_d   = acc_q;
            out_cnt_d   = cnt_q;
            out_ovf_d   = ovf_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
        end else if (state_q == StHold && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_prod_q   <= '0;
            s1_last_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_prod_q   <= s1_prod_d;
            s1_last_q   <= s1_last_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_sum_q   <= out_sum_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_braun_product_accumulator.sv
// Scoreboard bench for braun_product_accumulator (ACC_W=10 so the overflow case is reachable).
module tb_braun_product_accumulator;

    localparam int unsigned ACC_W = 10;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_prod = 8'd0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    braun_product_accumulator #(
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cnt  (out_cnt),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes on the next rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
            end
        end
    end

    task automatic push_exp(input int sum, input int cnt, input logic ovf);
        exp_t e;
        e.sum = ACC_W'(sum);
        e.cnt = CNT_W'(cnt);
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1
    task automatic send(input logic [7:0] p, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((out_valid || exp_q.size() != 0) && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_const(input int beats, input logic [7:0] p, input int gap);
        for (int i = 0; i < beats; i++) begin
            send(p, i == beats - 1);
            if (i != beats - 1) idle(gap);
        end
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Four back-to-back beats of 225 with latency checks
        out_ready = 1'b1;
        push_exp(900, 4, 1'b0);
        run_const(4, 8'd225, 0);
        chk("lat_t0_valid", 32'(out_valid), 32'd0);
        chk("lat_t0_ready", 32'(in_ready), 32'd0);
        idle(1);
        chk("lat_t1_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        idle(1);
        chk("lat_t2_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        wait_done();

        // Single beat, back-pressure for 5 cycles
        out_ready = 1'b0;
        push_exp(42, 1, 1'b0);
        send(8'd42, 1'b1);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'd42);
            chk("bp_cnt", 32'(out_cnt), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_done_in_ready", 32'(in_ready), 32'd1);
        wait_done();

        // Overflow: 5 * 225 = 1125 > 1023
`ifdef BRAUN_ACC_SATURATE_EN
        push_exp(1023, 5, 1'b1);
`else
        push_exp(101, 5, 1'b1);
`endif
        run_const(5, 8'd225, 0);
        wait_done();
        push_exp(7, 1, 1'b0);
        send(8'd7, 1'b1);
        wait_done();

        // Gapped input including a zero product
        push_exp(30, 3, 1'b0);
        send(8'd10, 1'b0);
        idle(3);
        send(8'd0, 1'b0);
        idle(3);
        send(8'd20, 1'b1);
        wait_done();

        // Counter wrap
        push_exp(16, 0, 1'b0);
        run_const(16, 8'd1, 0);
        wait_done();

        // Asynchronous reset mid-sequence
        send(8'd100, 1'b0);
        send(8'd50, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_sum", 32'(out_sum), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_cnt", 32'(out_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(11, 2, 1'b0);
        send(8'd5, 1'b0);
        send(8'd6, 1'b1);
        wait_done();

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
